// File: rtl/eth_rxseqctl.sv
// eth_rxseqctl: receive byte/IFG counters, qualifiers and end-of-frame status for the MAC rx path
module eth_rxseqctl #(
  parameter int IFG_NIBBLES = 24
) (
  input  logic        MRxClk,
  input  logic        Reset,
  input  logic        MRxDV,
  input  logic        StateIdle,
  input  logic        StateDrop,
  input  logic        StatePreamble,
  input  logic        StateSFD,
  input  logic [1:0]  StateData,
  input  logic [15:0] r_MaxFL,
  input  logic [15:0] r_MinFL,
  input  logic        r_HugEn,
  input  logic        r_IFG,
  output logic [15:0] ByteCnt,
  output logic        ByteCntEq0,
  output logic        ByteCntGreat2,
  output logic        ByteCntMaxFrame,
  output logic        IFGCounterEq24,
  output logic        RxEndFrm,
  output logic [15:0] RxFrmLen,
  output logic        RxShort,
  output logic        RxTooLong,
  output logic        RxDribble
);
  localparam logic [4:0] IfgMax = 5'(IFG_NIBBLES);
  logic [4:0] IFGCounter;
  logic inData, endNormal, endLong;
  assign inData          = |StateData;
  assign ByteCntEq0      = ByteCnt == 16'd0;
  assign ByteCntGreat2   = ByteCnt > 16'd2;
  assign ByteCntMaxFrame = (ByteCnt == r_MaxFL) & ~r_HugEn;
  assign IFGCounterEq24  = (IFGCounter == IfgMax) | r_IFG;
  assign endNormal       = inData & ~MRxDV;
  assign endLong         = StateData[0] & MRxDV & ByteCntMaxFrame;
  always_ff @(posedge MRxClk) begin
    if (Reset) begin
      ByteCnt    <= '0;
      IFGCounter <= '0;
      RxEndFrm   <= 1'b0;
      RxFrmLen   <= '0;
      RxShort    <= 1'b0;
      RxTooLong  <= 1'b0;
      RxDribble  <= 1'b0;
    end else begin
      ByteCnt <= !inData ? 16'd0 :
                 (StateData[1] & MRxDV & (ByteCnt != 16'hFFFF)) ? ByteCnt + 16'd1 : ByteCnt;
      IFGCounter <= (MRxDV & (inData | StateSFD)) ? 5'd0 :
                    ((StateIdle | StateDrop | StatePreamble) & (IFGCounter < IfgMax)) ? IFGCounter + 5'd1 :
                    IFGCounter;
      RxEndFrm <= endNormal | endLong;
      if (endNormal | endLong) begin
        RxFrmLen  <= ByteCnt;
        RxShort   <= ByteCnt < r_MinFL;
        RxTooLong <= endLong;
        RxDribble <= endNormal & StateData[1];
      end
    end
  end
endmodule
